regfile_op_sequencer: RTL

- Command-driven controller for the 8-bit general register file (R1-R4, T1-T4).
- Accepts one register-level command at a time over a valid/ready handshake.
- Expands each command into single-cycle write steps by driving FunSel, RSel, TSel, O1Sel, O2Sel and the register file Input bus.
- Sits between the control unit and the register file. Output1 of the register file is fed back so the block can perform copy and swap.

---
 rtl/regfile_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: expands register-level commands into single-cycle register file write steps.
// Define REGSEQ_ABORT_EN to add cmd_abort, which cuts INC/DEC short and ends with an error pulse.
module regfile_op_sequencer #(
  parameter int CNT_W = 4,
  parameter logic [2:0] SCRATCH = 3'b011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_dst,
  input  logic [2:0]       cmd_src,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [7:0]       cmd_data,
`ifdef REGSEQ_ABORT_EN
  input  logic             cmd_abort,
`endif
  input  logic [7:0]       reg_out1,
  output logic [7:0]       reg_input,
  output logic [1:0]       fun_sel,
  output logic [3:0]       r_sel,
  output logic [3:0]       t_sel,
  output logic [2:0]       o1_sel,
  output logic [2:0]       o2_sel,
  output logic             busy,
  output logic             done,
  output logic             error
);
  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, SWAP3, FIN} state_t;
  state_t           state;
  logic [2:0]       op_q, dst_q, src_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       data_q, wen;
  logic             fwd, abort, incdec;
`ifdef REGSEQ_ABORT_EN
  assign abort = cmd_abort;
`else
  assign abort = 1'b0;
`endif
  assign incdec = op_q == 3'd3 || op_q == 3'd4;
  assign t_sel = wen[3:0];
  assign r_sel = wen[7:4];
  // Copy and swap steps pass the register file's Output1 straight back so the write sees the selected value.
  assign reg_input = fwd ? reg_out1 : data_q;
  function automatic logic [7:0] onehot(input logic [2:0] c);
    return 8'b1 << c;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wen       <= '0;
      fun_sel   <= 2'b01;
      o1_sel    <= '0;
      o2_sel    <= '0;
      data_q    <= '0;
      fwd       <= 1'b0;
      op_q      <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done    <= 1'b0;
      error   <= 1'b0;
      wen     <= '0;
      fun_sel <= 2'b01;
      fwd     <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          op_q      <= cmd_op;
          dst_q     <= cmd_dst;
          src_q     <= cmd_src;
          data_q    <= cmd_data;
          o2_sel    <= cmd_src;
          cmd_ready <= 1'b0;
          case (cmd_op)
            3'd1, 3'd2: begin
              state   <= EXEC;
              busy    <= 1'b1;
              wen     <= onehot(cmd_dst);
              fun_sel <= cmd_op == 3'd1 ? 2'b00 : 2'b01;
            end
            3'd3, 3'd4: if (cmd_count == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= EXEC;
              busy    <= 1'b1;
              wen     <= onehot(cmd_dst);
              fun_sel <= cmd_op == 3'd3 ? 2'b11 : 2'b10;
              cnt_q   <= cmd_count - 1'b1;
            end
            3'd5: begin
              state  <= EXEC;
              busy   <= 1'b1;
              wen    <= onehot(cmd_dst);
              o1_sel <= cmd_src;
              fwd    <= 1'b1;
            end
            3'd6: if (cmd_src == SCRATCH || cmd_dst == SCRATCH || cmd_src == cmd_dst) begin
              state <= FIN;
              done  <= 1'b1;
              error <= cmd_src == SCRATCH || cmd_dst == SCRATCH;
            end else begin
              state  <= SWAP1;
              busy   <= 1'b1;
              wen    <= onehot(SCRATCH);
              o1_sel <= cmd_dst;
              fwd    <= 1'b1;
            end
            default: begin
              state <= FIN;
              done  <= 1'b1;
              error <= cmd_op == 3'd7;
            end
          endcase
        end
        EXEC: if (incdec && !abort && cnt_q != '0) begin
          cnt_q   <= cnt_q - 1'b1;
          wen     <= onehot(dst_q);
          fun_sel <= fun_sel;
        end else begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= !(incdec && abort);
          error <= incdec && abort;
        end
        SWAP1: begin
          state  <= SWAP2;
          wen    <= onehot(dst_q);
          o1_sel <= src_q;
          fwd    <= 1'b1;
        end
        SWAP2: begin
          state  <= SWAP3;
          wen    <= onehot(src_q);
          o1_sel <= SCRATCH;
          fwd    <= 1'b1;
        end
        SWAP3: begin
          state <= FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        FIN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
